// File: rtl/serial_adder_nbit.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder_nbit
// Function : Multi-cycle WIDTH-bit adder that processes CHUNK bits per clock.
//            The carry passes between slices in a register. Operation is
//            controlled by a start/busy/done handshake.
// Option   : `define SERADD_SUB_EN adds the 'sub' port, which selects
//            a - b (two's complement, cout=1 means no borrow).
// Revision : 1.0 - initial release
// ============================================================================
module serial_adder_nbit #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = $clog2(NCHUNK + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Reject geometries that cannot be sliced evenly.
  generate
    if ((WIDTH < 2) || (CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
      $error("serial_adder_nbit: WIDTH must be >= 2 and a multiple of CHUNK");
    end
  endgenerate

  logic [0:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carry;

  logic [CHUNK:0]   chunk_sum;
  logic [WIDTH-1:0] sum_next;
  logic             msb_carry_in;
  logic             last_chunk;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

  // Operand B and carry as they enter the registers. Subtraction loads ~b
  // with a forced carry of 1.
`ifdef SERADD_SUB_EN
  assign b_load = sub ? ~b : b;
  assign c_load = sub | cin;
`else
  assign b_load = b;
  assign c_load = cin;
`endif

  // One slice of the ripple adder. The new slice enters the sum register
  // from the top, so after NCHUNK slices the sum is aligned.
  always_comb begin
    chunk_sum    = {1'b0, a_reg[CHUNK-1:0]} + {1'b0, b_reg[CHUNK-1:0]}
                 + {{CHUNK{1'b0}}, carry};
    sum_next     = (sum_reg >> CHUNK) | (WIDTH'(chunk_sum[CHUNK-1:0]) << (WIDTH - CHUNK));
    msb_carry_in = a_reg[CHUNK-1] ^ b_reg[CHUNK-1] ^ chunk_sum[CHUNK-1];
    last_chunk   = (cnt == CW'(NCHUNK - 1));
  end

  // Control FSM and datapath registers. Visible results change only on the
  // completing edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      sum_reg <= '0;
      carry   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      s       <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_reg   <= a;
            b_reg   <= b_load;
            carry   <= c_load;
            sum_reg <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          a_reg   <= a_reg >> CHUNK;
          b_reg   <= b_reg >> CHUNK;
          sum_reg <= sum_next;
          carry   <= chunk_sum[CHUNK];
          cnt     <= cnt + CW'(1);
          if (last_chunk) begin
            s     <= sum_next;
            cout  <= chunk_sum[CHUNK];
            ovf   <= msb_carry_in ^ chunk_sum[CHUNK];
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_nbit.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_adder_nbit
// Function : Scoreboard bench for serial_adder_nbit (WIDTH=16, CHUNK=4).
//            The sub-select cases run only when SERADD_SUB_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_adder_nbit;

  localparam int W  = 16;
  localparam int C  = 4;
  localparam int NC = W / C;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b1;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          cin = 1'b0;
  logic          sub = 1'b0;
  logic          busy;
  logic          done;
  logic [W-1:0]  s;
  logic          cout;
  logic          ovf;

  serial_adder_nbit #(.WIDTH(W), .CHUNK(C)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERADD_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .s     (s),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
    int           cyc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic rst_seen = 1'b0;

  // Edge counter and the reset value seen at that edge.
  always @(posedge clk) begin
    cyc      = cyc + 1;
    rst_seen = rst;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic mc, input logic msub);
    exp_t e;
    int   ua, ub, total_u, sa, sb, sv;
    ua = int'(ma);
    ub = int'(mb);
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    if (msub) begin
      total_u = ua + ((1 << W) - 1 - ub) + 1;
      sv      = sa - sb;
    end else begin
      total_u = ua + ub + int'(mc);
      sv      = sa + sb + int'(mc);
    end
    e.s    = total_u[W-1:0];
    e.cout = total_u[W];
    e.ovf  = (sv > (1 << (W-1)) - 1) || (sv < -(1 << (W-1)));
    e.cyc  = 0;
    return e;
  endfunction

  // Monitor: pop and compare on every done; otherwise outputs must hold.
  logic [W-1:0] hold_s    = '0;
  logic         hold_cout = 1'b0;
  logic         hold_ovf  = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst_seen) begin
      hold_s = '0; hold_cout = 1'b0; hold_ovf = 1'b0;
    end
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'(0));
      end else begin
        e = exp_q.pop_front();
        chk("s",         32'(s),    32'(e.s));
        chk("cout",      32'(cout), 32'(e.cout));
        chk("ovf",       32'(ovf),  32'(e.ovf));
        chk("done_cyc",  32'(cyc),  32'(e.cyc));
        chk("busy_done", 32'(busy), 32'(0));
        hold_s = e.s; hold_cout = e.cout; hold_ovf = e.ovf;
      end
    end else if (cyc > 0) begin
      chk("hold_s",    32'(s),    32'(hold_s));
      chk("hold_cout", 32'(cout), 32'(hold_cout));
      chk("hold_ovf",  32'(ovf),  32'(hold_ovf));
    end
  end

  function automatic exp_t expect_at(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                     input logic mc, input logic msub, input int dcyc);
    exp_t e;
    e = model(ma, mb, mc, msub);
    e.cyc = dcyc;
    return e;
  endfunction

  // Issue one operation from a negedge; returns at the negedge of its done cycle.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic ic, input logic isub);
    a = ia; b = ib; cin = ic; sub = isub; start = 1'b1;
    exp_q.push_back(expect_at(ia, ib, ic, isub, cyc + 1 + NC));
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    for (int k = 0; k < NC; k++) begin
      chk("busy_run", 32'(busy), 32'(1));
      @(negedge clk);
    end
    chk("busy_after", 32'(busy), 32'(0));
  endtask

  task automatic reset_outputs_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'(0));
    chk({tag, "_done"}, 32'(done), 32'(0));
    chk({tag, "_s"},    32'(s),    32'(0));
    chk({tag, "_cout"}, 32'(cout), 32'(0));
    chk({tag, "_ovf"},  32'(ovf),  32'(0));
  endtask

  initial begin
    int t0;
    // Reset held two cycles with start asserted.
    repeat (2) @(negedge clk);
    reset_outputs_zero("rst");
    rst = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'(0));

    // Directed vectors.
    issue(16'h1234, 16'h0FCD, 1'b1, 1'b0);
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    issue(16'h8000, 16'h8000, 1'b1, 1'b0);

    // Start pulse during RUN is ignored.
    a = 16'h1234; b = 16'h0FCD; cin = 1'b1; start = 1'b1;
    exp_q.push_back(expect_at(16'h1234, 16'h0FCD, 1'b1, 1'b0, cyc + 1 + NC));
    @(negedge clk); start = 1'b0;
    @(negedge clk); a = 16'h0001; b = 16'h0001; cin = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (NC + 4) @(negedge clk);

    // Start held continuously: back-to-back acceptance.
    t0 = cyc + 1;
    a = 16'h00F0; b = 16'h0F0F; cin = 1'b0; start = 1'b1;
    exp_q.push_back(expect_at(16'h00F0, 16'h0F0F, 1'b0, 1'b0, t0 + NC));
    @(negedge clk);
    a = 16'hA5A5; b = 16'h5A5A; cin = 1'b1;
    exp_q.push_back(expect_at(16'hA5A5, 16'h5A5A, 1'b1, 1'b0, t0 + 2*NC + 1));
    repeat (NC + 1) @(negedge clk);
    start = 1'b0;
    repeat (NC + 3) @(negedge clk);

    // Randomized operations with random idle gaps.
    for (int i = 0; i < 30; i++) begin
      logic rs;
`ifdef SERADD_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      issue(W'($urandom), W'($urandom), 1'($urandom), rs);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Reset in the middle of an operation: no result is expected.
    a = 16'h4321; b = 16'h1111; cin = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    reset_outputs_zero("midrst");
    rst = 1'b0;
    repeat (NC + 2) @(negedge clk);
    issue(16'd3, 16'd4, 1'b0, 1'b0);

`ifdef SERADD_SUB_EN
    issue(16'h0005, 16'h0007, 1'b0, 1'b1);
    issue(16'h8000, 16'h0001, 1'b1, 1'b1);
`endif

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge clk);
    chk("pending", 32'(exp_q.size()), 32'(0));
    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
